// File: rtl/mag_est_stream.sv
// Streaming alpha-max-plus-beta-min magnitude estimator: three register stages
// (abs, sort, estimate) behind a valid/ready handshake, with per-frame mode and bin tags.
module mag_est_stream #(
  parameter int WIDTH = 12,
  parameter int N     = 256,
  localparam int IDXW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   real_in,
  input  logic [WIDTH:0]   imag_in,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] magnitude,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             frame_err
);

  logic            adv;
  logic            accept;
  logic [IDXW-1:0] bin_cnt;
  logic [1:0]      mode_q;
  logic            at_end;
  logic [1:0]      beat_mode;

  logic            s1_valid, s1_last;
  logic [WIDTH:0]  s1_a, s1_b;
  logic [IDXW-1:0] s1_idx;
  logic [1:0]      s1_mode;

  logic            s2_valid, s2_last;
  logic [WIDTH:0]  s2_mx, s2_mn;
  logic [IDXW-1:0] s2_idx;
  logic [1:0]      s2_mode;

  logic [WIDTH+1:0] mxw, mnw, trim, est;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign at_end    = (bin_cnt == IDXW'(N - 1));
  // Bin 0 uses the live mode input; the rest of the frame uses the latched copy.
  assign beat_mode = (bin_cnt == '0) ? mode : mode_q;

  // The unsigned WIDTH+1 result holds 2^WIDTH, so the most negative input does not wrap.
  function automatic logic [WIDTH:0] abs_val(input logic [WIDTH:0] x);
    return x[WIDTH] ? (~x + 1'b1) : x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      mode_q    <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      bin_cnt <= (in_last || at_end) ? '0 : bin_cnt + IDXW'(1);
      if (bin_cnt == '0)
        mode_q <= mode;
      if (in_last != at_end)
        frame_err <= 1'b1;
    end
  end

  always_comb begin
    mxw  = {1'b0, s2_mx};
    mnw  = {1'b0, s2_mn};
    trim = '0;
    est  = '0;
    case (s2_mode)
      2'd0: est = mxw + (mnw >> 1);
      2'd1: est = mxw + (mnw >> 2);
      2'd2: est = mxw - (mxw >> 4) + (mnw >> 1) - (mnw >> 5);
      default: begin
        trim = mxw - (mxw >> 3) + (mnw >> 1);
        est  = (trim > mxw) ? trim : mxw;
      end
    endcase
  end

  // Whole pipeline shares one enable; bubbles flow through rather than collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_idx    <= '0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_mx     <= '0;
      s2_mn     <= '0;
      s2_idx    <= '0;
      s2_mode   <= '0;
      out_valid <= 1'b0;
      magnitude <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last || at_end;
      s1_a      <= abs_val(real_in);
      s1_b      <= abs_val(imag_in);
      s1_idx    <= bin_cnt;
      s1_mode   <= beat_mode;

      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_mx     <= (s1_a >= s1_b) ? s1_a : s1_b;
      s2_mn     <= (s1_a >= s1_b) ? s1_b : s1_a;
      s2_idx    <= s1_idx;
      s2_mode   <= s1_mode;

      out_valid <= s2_valid;
      magnitude <= est;
      out_idx   <= s2_idx;
      out_last  <= s2_last;
    end
  end

endmodule
